// File: rtl/ripple_count_monitor.sv
// Filters and sequence-checks the asynchronous output of a free-running ripple counter.
// Optional stall detector is compiled in with RCM_STALL_DET_EN.
module ripple_count_monitor #(
  parameter int WIDTH   = 4,
  parameter int STABLE  = 2,
  parameter int ECW     = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] cnt_in_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] cur_val_o,
  output logic             locked_o,
  output logic             step_pulse_o,
  output logic             wrap_pulse_o,
  output logic             err_pulse_o,
  output logic [ECW-1:0]   err_cnt_o,
  output logic             stall_o
);

  localparam int SW = $clog2(STABLE + 1);
  localparam logic [0:0] ST_ACQ   = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  if (STABLE < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("ripple_count_monitor: STABLE and TIMEOUT must be >= 1");
  end

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [SW-1:0]    stab_q, stab_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d, cur_inc;
  logic             step_q, step_d, wrap_q, wrap_d, err_q, err_d;
  logic [ECW-1:0]   ecnt_q, ecnt_d;
  logic             same, accept;

  // s1 is the next value of s2, so comparing them is "s2 == previous s2" one stage early;
  // this gives STABLE+2 cycles from a steady input change to cur_val.
  assign same    = (s1_q == s2_q);
  assign accept  = same && (stab_q == SW'(STABLE - 1));
  assign cur_inc = cur_q + WIDTH'(1);

  always_comb begin
    stab_d = '0;
    if (same) stab_d = (stab_q == SW'(STABLE)) ? stab_q : stab_q + SW'(1);
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if (state_q == ST_ACQ) begin
        cur_d   = s2_q;
        state_d = ST_TRACK;
      end else if (s2_q == cur_inc) begin
        cur_d  = s2_q;
        step_d = 1'b1;
        wrap_d = &cur_q;
      end else if (s2_q != cur_q) begin
        cur_d = s2_q;
        err_d = 1'b1;
      end
    end
  end

  // A fresh error beats a coincident clear: the count restarts at 1.
  always_comb begin
    ecnt_d = ecnt_q;
    if (err_d) ecnt_d = clr_err_i ? ECW'(1) : ((&ecnt_q) ? ecnt_q : ecnt_q + ECW'(1));
    else if (clr_err_i) ecnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= '0;
      s2_q    <= '0;
      stab_q  <= '0;
      state_q <= ST_ACQ;
      cur_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      s1_q    <= cnt_in_i;
      s2_q    <= s1_q;
      stab_q  <= stab_d;
      state_q <= state_d;
      cur_q   <= cur_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign cur_val_o    = cur_q;
  assign locked_o     = (state_q == ST_TRACK);
  assign step_pulse_o = step_q;
  assign wrap_pulse_o = wrap_q;
  assign err_pulse_o  = err_q;
  assign err_cnt_o    = ecnt_q;

`ifdef RCM_STALL_DET_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;

  // Timer restarts on the same edge that raises step_pulse, so stall drops with it.
  always_comb begin
    timer_d = timer_q;
    if (state_q == ST_ACQ || step_d) timer_d = '0;
    else if (timer_q != TW'(TIMEOUT)) timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timer_q <= '0;
    else         timer_q <= timer_d;
  end

  assign stall_o = (timer_q == TW'(TIMEOUT));
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: stimulus pushes expected events, a negedge
// monitor pops them whenever the DUT locks, steps or flags an error.
module tb_ripple_count_monitor;
  logic       clk = 1'b0, rst_n = 1'b0, clr_err = 1'b0;
  logic [3:0] cnt_in = '0;
  logic [3:0] cur_val;
  logic       locked, step, wrap, err, stall;
  logic [7:0] ecnt;

  ripple_count_monitor #(.WIDTH(4), .STABLE(2), .ECW(8), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cnt_in_i(cnt_in), .clr_err_i(clr_err),
    .cur_val_o(cur_val), .locked_o(locked), .step_pulse_o(step), .wrap_pulse_o(wrap),
    .err_pulse_o(err), .err_cnt_o(ecnt), .stall_o(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cur;
    logic       step, wrap, err;
    logic [7:0] ecnt;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0, checks = 0;
  logic locked_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] c, input logic s, input logic w,
                              input logic e, input logic [7:0] n);
    exp_t r;
    r.cur = c; r.step = s; r.wrap = w; r.err = e; r.ecnt = n;
    return r;
  endfunction

  task automatic hold(input logic [3:0] v, input int n);
    cnt_in = v;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t got, e;
    if (!rst_n) locked_prev = 1'b0;
    else begin
      if (step || err || (locked && !locked_prev)) begin
        got = {cur_val, step, wrap, err, ecnt};
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got %h with no expectation at %0t", got, $time);
        end else begin
          e = sbq.pop_front();
          chk("scoreboard{cur,step,wrap,err,ecnt}", 32'(got), 32'(e));
        end
      end
      locked_prev = locked;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset held while the counter bus toggles: everything must stay cleared.
    for (int i = 0; i < 4; i++) begin
      #3 cnt_in = cnt_in ^ 4'hA;
      chk("reset_outputs", 32'({cur_val, locked, step, wrap, err, ecnt, stall}), 32'd0);
    end
    rst_n  = 1'b1;
    cnt_in = 4'd5;
    sbq.push_back(mk(4'd5, 1'b0, 1'b0, 1'b0, 8'd0));
    repeat (3) begin
      @(negedge clk);
      chk("locked_before_latency", 32'(locked), 32'd0);
    end
    @(negedge clk);
    chk("locked_after_4_cycles", 32'(locked), 32'd1);
    chk("acq_cur_val", 32'(cur_val), 32'd5);
    repeat (4) @(negedge clk);

    // Clean count 6..15,0 (wrap) then on to 7.
    for (int v = 6; v <= 16; v++) begin
      sbq.push_back(mk(4'(v), 1'b1, (4'(v) == 4'd0), 1'b0, 8'd0));
      hold(4'(v), 8);
    end
    for (int v = 1; v <= 7; v++) begin
      sbq.push_back(mk(4'(v), 1'b1, 1'b0, 1'b0, 8'd0));
      hold(4'(v), 8);
    end
    chk("err_cnt_after_steps", 32'(ecnt), 32'd0);

    // Ripple 7->8 through single-cycle transients.
    hold(4'd6, 1); hold(4'd4, 1); hold(4'd0, 1);
    sbq.push_back(mk(4'd8, 1'b1, 1'b0, 1'b0, 8'd0));
    hold(4'd8, 8);
    chk("ripple_cur_val", 32'(cur_val), 32'd8);

    // Sequence errors and clear.
    sbq.push_back(mk(4'd3, 1'b0, 1'b0, 1'b1, 8'd1));
    hold(4'd3, 8);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("clr_err_alone", 32'(ecnt), 32'd0);
    sbq.push_back(mk(4'd9, 1'b0, 1'b0, 1'b1, 8'd1));
    hold(4'd9, 8);
    chk("jump_cur_val", 32'(cur_val), 32'd9);
    chk("jump_err_cnt", 32'(ecnt), 32'd1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("clr_err_after_jump", 32'(ecnt), 32'd0);

    // Clear coincident with a new error: error wins, count = 1.
    sbq.push_back(mk(4'd2, 1'b0, 1'b0, 1'b1, 8'd1));
    cnt_in = 4'd2;
    repeat (3) @(negedge clk);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("clr_vs_err", 32'(ecnt), 32'd1);
    repeat (4) @(negedge clk);

    // Drive err_cnt into saturation.
    for (int i = 0; i < 260; i++) begin
      logic [3:0] v;
      v = (i % 2 == 1) ? 4'd0 : 4'd8;
      sbq.push_back(mk(v, 1'b0, 1'b0, 1'b1, (i + 2 > 255) ? 8'd255 : 8'(i + 2)));
      hold(v, 5);
    end
    chk("err_cnt_saturated", 32'(ecnt), 32'd255);

`ifdef RCM_STALL_DET_EN
    sbq.push_back(mk(4'd1, 1'b1, 1'b0, 1'b0, 8'd255));
    cnt_in = 4'd1;
    k = 0;
    while (!step && k < 10) begin @(negedge clk); k++; end
    chk("stall_step_seen", 32'(step), 32'd1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 15) chk("stall_before_timeout", 32'(stall), 32'd0);
      if (c == 16) chk("stall_at_timeout", 32'(stall), 32'd1);
    end
    repeat (4) @(negedge clk);
    chk("stall_held", 32'(stall), 32'd1);
    sbq.push_back(mk(4'd2, 1'b1, 1'b0, 1'b0, 8'd255));
    cnt_in = 4'd2;
    k = 0;
    while (!step && k < 10) begin @(negedge clk); k++; end
    chk("stall_step2_seen", 32'(step), 32'd1);
    chk("stall_cleared_by_step", 32'(stall), 32'd0);
    repeat (4) @(negedge clk);
`else
    sbq.push_back(mk(4'd1, 1'b1, 1'b0, 1'b0, 8'd255));
    hold(4'd1, 30);
    chk("stall_tied_low", 32'(stall), 32'd0);
`endif

    // Reset mid-run, before the pending value can be accepted.
    cnt_in = 4'd5;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk("midrun_reset_outputs", 32'({cur_val, locked, step, wrap, err, ecnt, stall}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sbq.push_back(mk(4'd5, 1'b0, 1'b0, 1'b0, 8'd0));
    hold(4'd5, 8);
    chk("relock_after_reset", 32'(locked), 32'd1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
